// File: rtl/branch_resolve_unit_if.sv
// Fetch/EX-side branch bundle and BHT update/flush bundle
// for the branch resolve unit.
interface branch_resolve_unit_if #(
  parameter int PC_W  = 64,
  parameter int LOWER = 7
);
  logic             push;
  logic [PC_W-1:0]  push_pc;
  logic             push_pred;
  logic             resolve;
  logic             resolve_taken;
  logic             resolve_jump;
  logic [PC_W-1:0]  resolve_target;
  logic             bht_we;
  logic [LOWER-1:0] bht_write_addr;
  logic             bht_was_taken;
  logic             bht_jumped;
  logic             flush;
  logic [PC_W-1:0]  redirect_pc;

  modport master (
    output push, push_pc, push_pred,
    output resolve, resolve_taken,
    output resolve_jump, resolve_target,
    input  bht_we, bht_write_addr,
    input  bht_was_taken, bht_jumped,
    input  flush, redirect_pc
  );

  modport slave (
    input  push, push_pc, push_pred,
    input  resolve, resolve_taken,
    input  resolve_jump, resolve_target,
    output bht_we, bht_write_addr,
    output bht_was_taken, bht_jumped,
    output flush, redirect_pc
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// In-order queue of predicted branches; resolves them against EX,
// emits BHT updates and one-cycle mispredict flushes.
module branch_resolve_unit #(
  parameter  int LOWER = 7,
  parameter  int PC_W  = 64,
  parameter  int DEPTH = 4,
  parameter  int CNT_W = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CW    = PTR_W + 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             en,
  branch_resolve_unit_if.slave bif,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             underflow,
  output logic [CNT_W-1:0] mispredict_cnt
);

  logic [PC_W-1:0]  mem_pc   [DEPTH];
  logic             mem_pred [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic [PC_W-1:0]  head_pc;
  logic             head_pred;
  logic             actual;
  logic             pop;
  logic             mis;
  logic             acc;
  logic [CW-1:0]    cnt_nxt;

  always_comb begin
    head_pc   = mem_pc[rd_ptr];
    head_pred = mem_pred[rd_ptr];
    actual    = bif.resolve_taken | bif.resolve_jump;
    pop       = en & bif.resolve & ~empty;
    mis       = pop & (actual != head_pred);
    // a pop frees the slot the push lands in, so full is no obstacle
    acc       = en & bif.push & (~full | pop) & ~mis;
    cnt_nxt   = count;
    if (mis)
      cnt_nxt = '0;
    else if (acc && !pop)
      cnt_nxt = count + CW'(1);
    else if (!acc && pop)
      cnt_nxt = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (arst_n && acc) begin
      mem_pc[wr_ptr]   <= bif.push_pc;
      mem_pred[wr_ptr] <= bif.push_pred;
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      full               <= 1'b0;
      empty              <= 1'b1;
      underflow          <= 1'b0;
      mispredict_cnt     <= '0;
      bif.bht_we         <= 1'b0;
      bif.bht_write_addr <= '0;
      bif.bht_was_taken  <= 1'b0;
      bif.bht_jumped     <= 1'b0;
      bif.flush          <= 1'b0;
      bif.redirect_pc    <= '0;
    end else begin
      bif.bht_we <= 1'b0;
      bif.flush  <= 1'b0;
      if (en) begin
        count <= cnt_nxt;
        full  <= (cnt_nxt == CW'(DEPTH));
        empty <= (cnt_nxt == '0);
        if (bif.resolve && empty)
          underflow <= 1'b1;
        if (pop) begin
          bif.bht_we         <= 1'b1;
          bif.bht_write_addr <= head_pc[LOWER-1:0];
          bif.bht_was_taken  <= bif.resolve_taken;
          bif.bht_jumped     <= bif.resolve_jump;
        end
        if (mis) begin
          bif.flush       <= 1'b1;
          bif.redirect_pc <= actual ? bif.resolve_target
                                    : head_pc + PC_W'(4);
          wr_ptr          <= '0;
          rd_ptr          <= '0;
          if (mispredict_cnt != '1)
            mispredict_cnt <= mispredict_cnt + CNT_W'(1);
        end else begin
          if (acc)
            wr_ptr <= wr_ptr + PTR_W'(1);
          if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench: reference queue model plus scoreboard of
// expected BHT updates/flushes.
module tb_branch_resolve_unit;
  localparam int LOWER = 7;
  localparam int PC_W  = 64;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic            pd;
  } ent_t;

  typedef struct {
    logic [LOWER-1:0] addr;
    logic             tk;
    logic             jp;
    logic             fl;
    logic [PC_W-1:0]  rd;
  } exp_t;

  logic             clk = 1'b0;
  logic             arst_n;
  logic             en;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             underflow;
  logic [CNT_W-1:0] mispredict_cnt;

  branch_resolve_unit_if #(.PC_W(PC_W), .LOWER(LOWER)) bif ();

  branch_resolve_unit #(
    .LOWER(LOWER), .PC_W(PC_W),
    .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .en            (en),
    .bif           (bif),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .underflow     (underflow),
    .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_err = 0;
  ent_t mq[$];
  exp_t sbq[$];
  logic m_under;
  int   m_mis;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic p, input logic [PC_W-1:0] pc,
                      input logic pd, input logic r,
                      input logic tk, input logic jp,
                      input logic [PC_W-1:0] tg, input logic e);
    logic exp_we;
    logic exp_fl;
    logic mis;
    ent_t h;
    exp_t x;
    exp_t g;
    exp_we = 1'b0;
    exp_fl = 1'b0;
    mis    = 1'b0;
    bif.push           = p;
    bif.push_pc        = pc;
    bif.push_pred      = pd;
    bif.resolve        = r;
    bif.resolve_taken  = tk;
    bif.resolve_jump   = jp;
    bif.resolve_target = tg;
    en                 = e;
    if (e) begin
      if (r) begin
        if (mq.size() == 0) begin
          m_under = 1'b1;
        end else begin
          h      = mq.pop_front();
          mis    = ((tk | jp) != h.pd);
          exp_we = 1'b1;
          exp_fl = mis;
          x.addr = h.pc[LOWER-1:0];
          x.tk   = tk;
          x.jp   = jp;
          x.fl   = mis;
          x.rd   = (tk | jp) ? tg : h.pc + 64'd4;
          sbq.push_back(x);
          if (mis) begin
            mq.delete();
            if (m_mis < 65535) m_mis++;
          end
        end
      end
      if (p && !mis && mq.size() < DEPTH) begin
        h.pc = pc;
        h.pd = pd;
        mq.push_back(h);
      end
    end
    @(posedge clk);
    #1;
    bif.push    = 1'b0;
    bif.resolve = 1'b0;
    chk("bht_we", bif.bht_we, exp_we);
    chk("flush", bif.flush, exp_fl);
    if (bif.bht_we) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected", 1, 0);
      end else begin
        g = sbq.pop_front();
        chk("bht_write_addr", bif.bht_write_addr, g.addr);
        chk("bht_was_taken", bif.bht_was_taken, g.tk);
        chk("bht_jumped", bif.bht_jumped, g.jp);
        if (g.fl) chk("redirect_pc", bif.redirect_pc, g.rd);
      end
    end
    chk("count", count, mq.size());
    chk("full", full, mq.size() == DEPTH);
    chk("empty", empty, mq.size() == 0);
    chk("underflow", underflow, m_under);
    chk("mispredict_cnt", mispredict_cnt, m_mis);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic push1(input logic [PC_W-1:0] pc, input logic pd);
    step(1, pc, pd, 0, 0, 0, 0, 1);
  endtask

  task automatic res1(input logic tk, input logic jp,
                      input logic [PC_W-1:0] tg);
    step(0, 0, 0, 1, tk, jp, tg, 1);
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    bif.push    = 1'b0;
    bif.resolve = 1'b0;
    mq.delete();
    sbq.delete();
    m_under = 1'b0;
    m_mis   = 0;
    chk("rst_bht_we", bif.bht_we, 0);
    chk("rst_flush", bif.flush, 0);
    chk("rst_addr", bif.bht_write_addr, 0);
    chk("rst_taken", bif.bht_was_taken, 0);
    chk("rst_jumped", bif.bht_jumped, 0);
    chk("rst_redirect", bif.redirect_pc, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_mis", mispredict_cnt, 0);
  endtask

  initial begin
    logic [CW-1:0] c_hold;
    arst_n             = 1'b0;
    en                 = 1'b1;
    bif.push           = 1'b0;
    bif.push_pc        = '0;
    bif.push_pred      = 1'b0;
    bif.resolve        = 1'b0;
    bif.resolve_taken  = 1'b0;
    bif.resolve_jump   = 1'b0;
    bif.resolve_target = '0;
    m_under = 1'b0;
    m_mis   = 0;
    #2;
    do_reset();

    push1(64'h100, 0);
    idle();
    res1(0, 0, 64'h0);
    idle();

    push1(64'h104, 0);
    res1(1, 0, 64'h200);
    chk("tp2_redirect", bif.redirect_pc, 64'h200);
    idle();

    push1(64'h10, 1);
    push1(64'h20, 0);
    push1(64'h30, 0);
    res1(0, 0, 64'h999);
    chk("tp3_redirect", bif.redirect_pc, 64'h14);
    chk("tp3_count", count, 0);

    for (int i = 0; i < 4; i++)
      push1(64'h40 + 64'(i * 4), i[0]);
    chk("tp4_full", full, 1);
    push1(64'h50, 0);
    chk("tp4_drop", count, 4);
    step(1, 64'h54, 1, 1, 0, 0, 0, 1);
    chk("tp4_pr_count", count, 4);
    res1(1, 0, 64'h500);
    res1(0, 0, 64'h0);
    res1(1, 1, 64'h600);
    res1(1, 0, 64'h700);
    chk("tp4_empty", empty, 1);

    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 64'($urandom) << 2,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
           64'($urandom) << 2, 1);
    while (mq.size() != 0)
      res1(mq[0].pd, 0, 64'h800);

    res1(1, 0, 64'h0);
    chk("tp5_underflow", underflow, 1);
    idle();
    push1(64'h60, 1);
    chk("tp5_sticky", underflow, 1);

    push1(64'h64, 1);
    c_hold = count;
    for (int i = 0; i < 3; i++)
      step(1, 64'h70, 0, 1, 0, 0, 64'h0, 0);
    chk("tp6_hold", count, c_hold);
    res1(0, 0, 64'h0);
    chk("tp6_flush_pre", bif.flush, 1);
    bif.resolve       = 1'b1;
    bif.resolve_taken = 1'b0;
    bif.push          = 1'b1;
    do_reset();
    idle();

    chk("sb_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
